// File: rtl/rvfi_pack_serializer.sv
// Gathers NRET lanes of RVFI retirements per cycle into a FIFO and replays them one per cycle, in lane order.
// Optional order checker is built when RVFI_PACK_ORDER_CHECK_EN is defined; otherwise order_err_o is tied 0.
module rvfi_pack_serializer #(
   parameter int NRET  = 2,
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NRET-1:0]        valid_i,
   input  logic [NRET*64-1:0]     order_i,
   input  logic [NRET*ILEN-1:0]   insn_i,
   input  logic [NRET-1:0]        trap_i,
   input  logic [NRET*XLEN-1:0]   cause_i,
   input  logic [NRET*2-1:0]      mode_i,
   input  logic [NRET*5-1:0]      rd_addr_i,
   input  logic [NRET*XLEN-1:0]   rd_wdata_i,
   input  logic [NRET*XLEN-1:0]   pc_rdata_i,
   input  logic [NRET*XLEN-1:0]   pc_wdata_i,
   input  logic [NRET*XLEN-1:0]   mem_addr_i,
   input  logic [NRET*XLEN/8-1:0] mem_rmask_i,
   input  logic [NRET*XLEN/8-1:0] mem_wmask_i,
   output logic                   in_ready_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [63:0]            out_order_o,
   output logic [ILEN-1:0]        out_insn_o,
   output logic                   out_trap_o,
   output logic [XLEN-1:0]        out_cause_o,
   output logic [1:0]             out_mode_o,
   output logic [4:0]             out_rd_addr_o,
   output logic [XLEN-1:0]        out_rd_wdata_o,
   output logic [XLEN-1:0]        out_pc_rdata_o,
   output logic [XLEN-1:0]        out_pc_wdata_o,
   output logic [XLEN-1:0]        out_mem_addr_o,
   output logic [XLEN/8-1:0]      out_mem_rmask_o,
   output logic [XLEN/8-1:0]      out_mem_wmask_o,
   output logic                   overflow_o,
   output logic                   order_err_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int MW = XLEN / 8;

   typedef struct packed {
      logic [63:0]     order;
      logic [ILEN-1:0] insn;
      logic            trap;
      logic [XLEN-1:0] cause;
      logic [1:0]      mode;
      logic [4:0]      rd_addr;
      logic [XLEN-1:0] rd_wdata;
      logic [XLEN-1:0] pc_rdata;
      logic [XLEN-1:0] pc_wdata;
      logic [XLEN-1:0] mem_addr;
      logic [MW-1:0]   mem_rmask;
      logic [MW-1:0]   mem_wmask;
   } entry_t;

   entry_t          r_mem [DEPTH];
   entry_t          r_last;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;

   entry_t          w_lane [NRET];
   logic [PW-1:0]   w_idx  [NRET];
   logic [CW-1:0]   w_k;
   logic            w_push;
   logic            w_drop;
   logic            w_pop;
   entry_t          w_head;
   entry_t          w_out;

   // NOTE: w_k is a running popcount, so this block relies on blocking assignments evaluated in lane order.
   always_comb begin
      w_k = '0;
      for (int i = 0; i < NRET; i++) begin
         w_lane[i] = '{order:     order_i[i*64 +: 64],
                       insn:      insn_i[i*ILEN +: ILEN],
                       trap:      trap_i[i],
                       cause:     cause_i[i*XLEN +: XLEN],
                       mode:      mode_i[i*2 +: 2],
                       rd_addr:   rd_addr_i[i*5 +: 5],
                       rd_wdata:  rd_wdata_i[i*XLEN +: XLEN],
                       pc_rdata:  pc_rdata_i[i*XLEN +: XLEN],
                       pc_wdata:  pc_wdata_i[i*XLEN +: XLEN],
                       mem_addr:  mem_addr_i[i*XLEN +: XLEN],
                       mem_rmask: mem_rmask_i[i*MW +: MW],
                       mem_wmask: mem_wmask_i[i*MW +: MW]};
         w_idx[i] = r_wr_ptr + PW'(w_k);
         w_k      = w_k + CW'(valid_i[i]);
      end
   end

   assign in_ready_o  = (r_count <= CW'(DEPTH - NRET));
   assign out_valid_o = (r_count != '0);
   assign w_push      = (|valid_i) && in_ready_o;
   assign w_drop      = (|valid_i) && !in_ready_o;
   assign w_pop       = out_valid_o && out_ready_i;
   assign w_head      = r_mem[r_rd_ptr];

   // NOTE: storage has no reset; r_count alone decides which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         for (int i = 0; i < NRET; i++) begin
            if (valid_i[i]) r_mem[w_idx[i]] <= w_lane[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(w_k);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
            r_last   <= w_head;
         end
         r_count <= r_count + (w_push ? w_k : CW'(0)) - CW'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

`ifdef RVFI_PACK_ORDER_CHECK_EN
   logic [63:0] r_exp_order;
   logic        r_order_err;

   // Expected order resyncs to the popped value so one gap reports once, not forever.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_exp_order <= '0;
         r_order_err <= 1'b0;
      end else if (w_pop) begin
         if (w_head.order != r_exp_order) r_order_err <= 1'b1;
         r_exp_order <= w_head.order + 64'd1;
      end
   end

   assign order_err_o = r_order_err;
`else
   assign order_err_o = 1'b0;
`endif

   // When empty the outputs keep showing the last entry that left.
   assign w_out           = out_valid_o ? w_head : r_last;
   assign overflow_o      = r_overflow;
   assign out_order_o     = w_out.order;
   assign out_insn_o      = w_out.insn;
   assign out_trap_o      = w_out.trap;
   assign out_cause_o     = w_out.cause;
   assign out_mode_o      = w_out.mode;
   assign out_rd_addr_o   = w_out.rd_addr;
   assign out_rd_wdata_o  = w_out.rd_wdata;
   assign out_pc_rdata_o  = w_out.pc_rdata;
   assign out_pc_wdata_o  = w_out.pc_wdata;
   assign out_mem_addr_o  = w_out.mem_addr;
   assign out_mem_rmask_o = w_out.mem_rmask;
   assign out_mem_wmask_o = w_out.mem_wmask;

endmodule

// File: tb/tb_rvfi_pack_serializer.sv
// Directed bench for rvfi_pack_serializer (NRET=2, DEPTH=8): vector table plus multi-cycle sequences.
module tb_rvfi_pack_serializer;
   localparam int NRET  = 2;
   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 8;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic [NRET-1:0]        valid_i;
   logic [NRET*64-1:0]     order_i;
   logic [NRET*ILEN-1:0]   insn_i;
   logic [NRET-1:0]        trap_i;
   logic [NRET*XLEN-1:0]   cause_i;
   logic [NRET*2-1:0]      mode_i;
   logic [NRET*5-1:0]      rd_addr_i;
   logic [NRET*XLEN-1:0]   rd_wdata_i;
   logic [NRET*XLEN-1:0]   pc_rdata_i;
   logic [NRET*XLEN-1:0]   pc_wdata_i;
   logic [NRET*XLEN-1:0]   mem_addr_i;
   logic [NRET*XLEN/8-1:0] mem_rmask_i;
   logic [NRET*XLEN/8-1:0] mem_wmask_i;
   logic                   in_ready_o;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [63:0]            out_order_o;
   logic [ILEN-1:0]        out_insn_o;
   logic                   out_trap_o;
   logic [XLEN-1:0]        out_cause_o;
   logic [1:0]             out_mode_o;
   logic [4:0]             out_rd_addr_o;
   logic [XLEN-1:0]        out_rd_wdata_o;
   logic [XLEN-1:0]        out_pc_rdata_o;
   logic [XLEN-1:0]        out_pc_wdata_o;
   logic [XLEN-1:0]        out_mem_addr_o;
   logic [XLEN/8-1:0]      out_mem_rmask_o;
   logic [XLEN/8-1:0]      out_mem_wmask_o;
   logic                   overflow_o;
   logic                   order_err_o;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef RVFI_PACK_ORDER_CHECK_EN
   localparam logic EXP_GAP_ERR = 1'b1;
`else
   localparam logic EXP_GAP_ERR = 1'b0;
`endif

   rvfi_pack_serializer #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .order_i(order_i), .insn_i(insn_i),
      .trap_i(trap_i), .cause_i(cause_i), .mode_i(mode_i), .rd_addr_i(rd_addr_i),
      .rd_wdata_i(rd_wdata_i), .pc_rdata_i(pc_rdata_i), .pc_wdata_i(pc_wdata_i),
      .mem_addr_i(mem_addr_i), .mem_rmask_i(mem_rmask_i), .mem_wmask_i(mem_wmask_i),
      .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_trap_o(out_trap_o),
      .out_cause_o(out_cause_o), .out_mode_o(out_mode_o), .out_rd_addr_o(out_rd_addr_o),
      .out_rd_wdata_o(out_rd_wdata_o), .out_pc_rdata_o(out_pc_rdata_o),
      .out_pc_wdata_o(out_pc_wdata_o), .out_mem_addr_o(out_mem_addr_o),
      .out_mem_rmask_o(out_mem_rmask_o), .out_mem_wmask_o(out_mem_wmask_o),
      .overflow_o(overflow_o), .order_err_o(order_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  valid;
      logic [63:0] o0;
      logic [63:0] o1;
      logic        rdy;
      logic        e_ir;
      logic        e_v;
      logic [63:0] e_ord;
      logic        e_ov;
   } vec_t;

   vec_t vt [20];

   function automatic vec_t mk(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                               input logic rdy, input logic e_ir, input logic e_v,
                               input logic [63:0] e_ord, input logic e_ov);
      vec_t r;
      r.valid = v; r.o0 = o0; r.o1 = o1; r.rdy = rdy;
      r.e_ir = e_ir; r.e_v = e_v; r.e_ord = e_ord; r.e_ov = e_ov;
      return r;
   endfunction

   // Payload signature derived from the order number: {insn, pc_rdata[31:0]}.
   function automatic logic [63:0] sig(input logic [63:0] ord);
      return {ord[31:0] ^ 32'hDEADBEEF, ord[29:0], 2'b00};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_lane(input int lane, input logic [63:0] ord);
      logic [31:0] ins;
      ins = ord[31:0] ^ 32'hDEADBEEF;
      order_i[lane*64 +: 64]       = ord;
      insn_i[lane*ILEN +: ILEN]    = ins;
      trap_i[lane]                 = ord[0];
      cause_i[lane*XLEN +: XLEN]   = ord + 64'd100;
      mode_i[lane*2 +: 2]          = ord[1:0];
      rd_addr_i[lane*5 +: 5]       = ord[4:0];
      rd_wdata_i[lane*XLEN +: XLEN] = ~ord;
      pc_rdata_i[lane*XLEN +: XLEN] = ord << 2;
      pc_wdata_i[lane*XLEN +: XLEN] = (ord << 2) + 64'd4;
      mem_addr_i[lane*XLEN +: XLEN] = ord + 64'h1000;
      mem_rmask_i[lane*8 +: 8]     = ord[7:0];
      mem_wmask_i[lane*8 +: 8]     = ~ord[7:0];
   endtask

   task automatic set_group(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
      valid_i = v;
      drive_lane(0, o0);
      drive_lane(1, o1);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      out_ready_i = 1'b0;
      set_group(2'b00, 64'd0, 64'd0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   initial begin
      int exp_ord;
      int next_push;

      // Columns: valid, lane0 order, lane1 order, out_ready | in_ready, out_valid, out_order, overflow
      vt[0]  = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b0, 64'd0,  1'b0);
      vt[1]  = mk(2'b11, 64'd0,  64'd1,  1'b1, 1'b1, 1'b1, 64'd0,  1'b0);
      vt[2]  = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd1,  1'b0);
      vt[3]  = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b0, 64'd1,  1'b0);
      vt[4]  = mk(2'b10, 64'd99, 64'd2,  1'b0, 1'b1, 1'b1, 64'd2,  1'b0);
      vt[5]  = mk(2'b01, 64'd3,  64'd98, 1'b0, 1'b1, 1'b1, 64'd2,  1'b0);
      vt[6]  = mk(2'b11, 64'd4,  64'd5,  1'b0, 1'b1, 1'b1, 64'd2,  1'b0);
      vt[7]  = mk(2'b11, 64'd6,  64'd7,  1'b0, 1'b1, 1'b1, 64'd2,  1'b0);
      vt[8]  = mk(2'b11, 64'd8,  64'd9,  1'b0, 1'b0, 1'b1, 64'd2,  1'b0);
      vt[9]  = mk(2'b11, 64'd50, 64'd51, 1'b0, 1'b0, 1'b1, 64'd2,  1'b1);
      vt[10] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b0, 1'b1, 64'd3,  1'b1);
      vt[11] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd4,  1'b1);
      vt[12] = mk(2'b11, 64'd10, 64'd11, 1'b1, 1'b0, 1'b1, 64'd5,  1'b1);
      vt[13] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd6,  1'b1);
      vt[14] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd7,  1'b1);
      vt[15] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd8,  1'b1);
      vt[16] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd9,  1'b1);
      vt[17] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd10, 1'b1);
      vt[18] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b1, 64'd11, 1'b1);
      vt[19] = mk(2'b00, 64'd0,  64'd0,  1'b1, 1'b1, 1'b0, 64'd11, 1'b1);

      // Reset, then idle for 10 cycles.
      do_reset();
      check("reset_order", out_order_o, 64'd0);
      for (int c = 0; c < 10; c++) begin
         check("idle_in_ready", 64'(in_ready_o), 64'd1);
         check("idle_out_valid", 64'(out_valid_o), 64'd0);
         check("idle_overflow", 64'(overflow_o), 64'd0);
         check("idle_order_err", 64'(order_err_o), 64'd0);
         tick();
      end

      // Vector table: each row's expectations are the state after its clock edge.
      for (int i = 0; i < 20; i++) begin
         set_group(vt[i].valid, vt[i].o0, vt[i].o1);
         out_ready_i = vt[i].rdy;
         tick();
         check($sformatf("vec%0d_in_ready", i), 64'(in_ready_o), 64'(vt[i].e_ir));
         check($sformatf("vec%0d_out_valid", i), 64'(out_valid_o), 64'(vt[i].e_v));
         check($sformatf("vec%0d_out_order", i), out_order_o, vt[i].e_ord);
         check($sformatf("vec%0d_overflow", i), 64'(overflow_o), 64'(vt[i].e_ov));
         if (vt[i].e_v)
            check($sformatf("vec%0d_payload", i), {out_insn_o, out_pc_rdata_o[31:0]}, sig(vt[i].e_ord));
      end
      check("vec_stream_order_err", 64'(order_err_o), 64'd0);

      // Gap on lane 0: lane 1 alone carries order 5 while the checker expects 0.
      do_reset();
      set_group(2'b10, 64'd77, 64'd5);
      out_ready_i = 1'b1;
      tick();
      check("gap_out_valid", 64'(out_valid_o), 64'd1);
      check("gap_out_order", out_order_o, 64'd5);
      check("gap_mode", 64'(out_mode_o), 64'd1);
      set_group(2'b00, 64'd0, 64'd0);
      tick();
      check("gap_single_entry", 64'(out_valid_o), 64'd0);
      check("gap_hold_order", out_order_o, 64'd5);
      check("gap_order_err", 64'(order_err_o), 64'(EXP_GAP_ERR));

      // Fill, then drain with out_ready toggling while refilling whenever in_ready.
      do_reset();
      for (int g = 0; g < 4; g++) begin
         set_group(2'b11, 64'(2*g), 64'(2*g+1));
         tick();
      end
      set_group(2'b00, 64'd0, 64'd0);
      check("stream_full_in_ready", 64'(in_ready_o), 64'd0);
      exp_ord   = 0;
      next_push = 8;
      for (int c = 0; c < 200 && exp_ord < 32; c++) begin
         out_ready_i = c[0];
         if (in_ready_o && next_push < 32) begin
            set_group(2'b11, 64'(next_push), 64'(next_push + 1));
            next_push += 2;
         end else begin
            set_group(2'b00, 64'd0, 64'd0);
         end
         if (out_valid_o && out_ready_i) begin
            check("stream_order", out_order_o, 64'(exp_ord));
            exp_ord++;
         end
         tick();
      end
      set_group(2'b00, 64'd0, 64'd0);
      out_ready_i = 1'b0;
      check("stream_emitted", 64'(exp_ord), 64'd32);
      check("stream_overflow", 64'(overflow_o), 64'd0);
      check("stream_order_err", 64'(order_err_o), 64'd0);

      // Overflow with contents intact, then async reset while five entries remain.
      do_reset();
      for (int g = 0; g < 4; g++) begin
         set_group(2'b11, 64'(100 + 2*g), 64'(101 + 2*g));
         tick();
      end
      set_group(2'b11, 64'd200, 64'd201);
      tick();
      check("ovf_flag", 64'(overflow_o), 64'd1);
      check("ovf_in_ready", 64'(in_ready_o), 64'd0);
      check("ovf_head", out_order_o, 64'd100);
      set_group(2'b00, 64'd0, 64'd0);
      out_ready_i = 1'b1;
      for (int p = 0; p < 8; p++) begin
         if (p < 3) begin
            tick();
         end
      end
      out_ready_i = 1'b0;
      check("ovf_head_after_3", out_order_o, 64'd103);
      check("ovf_payload", {out_insn_o, out_pc_rdata_o[31:0]}, sig(64'd103));
      rst_ni = 1'b0;
      #2;
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      check("rst_overflow", 64'(overflow_o), 64'd0);
      check("rst_order_err", 64'(order_err_o), 64'd0);
      check("rst_out_order", out_order_o, 64'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      check("rst_still_empty", 64'(out_valid_o), 64'd0);
      set_group(2'b11, 64'd300, 64'd301);
      tick();
      check("post_rst_head", out_order_o, 64'd300);
      set_group(2'b00, 64'd0, 64'd0);
      out_ready_i = 1'b1;
      tick();
      check("post_rst_next", out_order_o, 64'd301);
      tick();
      check("post_rst_drained", 64'(out_valid_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
